// File: rtl/turn_sequencer.sv
// turn_sequencer
// Game-flow controller for an N-seat turn-based board game. Seats are served
// round-robin; each turn goes either to the human input path (player_prompt)
// or to the computer move engine (comp_go / comp_done). A human turn is
// forfeited on timeout or after too many illegal moves. After every accepted
// move the board result (win / filled) is evaluated for one cycle, and the
// game then either ends in OVER or passes to the next seat.
//
// Handshakes: player_prompt is a level that stays high for the whole human
// turn; a move is taken on any cycle in which player_prompt and move_valid are
// both high (wrong_move only qualifies it). comp_go is a single-cycle request;
// the engine answers with comp_done, which is only honoured while the
// controller is waiting for it. win/filled are only looked at in CHECK.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start               begin a new game (only honoured in IDLE or OVER)
//   move_valid          human move submitted this cycle
//   wrong_move          the submitted human move is illegal
//   comp_done           computer engine has committed its move
//   win, filled         board status, sampled in CHECK
//   turn                current seat index
//   player_prompt       human seat may move
//   comp_go             one-cycle start pulse for the computer engine
//   game_over           game has ended (OVER)
//   winner/winner_valid winning seat, qualified by winner_valid
//   draw                game ended with a full board and no win
//   skip                one-cycle pulse when a turn is forfeited
//   move_count          accepted moves this game, saturating
//   state_dbg           current FSM state, for observation only
module turn_sequencer #(
  parameter int                     NUM_PLAYERS    = 2,
  parameter logic [NUM_PLAYERS-1:0] COMP_MASK      = 2'b10,
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter int                     MAX_STRIKES    = 3,
  parameter int                     MOVE_W         = 8,
  localparam int                    PW             = (NUM_PLAYERS <= 2) ? 1 : $clog2(NUM_PLAYERS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              move_valid,
  input  logic              wrong_move,
  input  logic              comp_done,
  input  logic              win,
  input  logic              filled,
  output logic [PW-1:0]     turn,
  output logic              player_prompt,
  output logic              comp_go,
  output logic              game_over,
  output logic [PW-1:0]     winner,
  output logic              winner_valid,
  output logic              draw,
  output logic              skip,
  output logic [MOVE_W-1:0] move_count,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PROMPT = 3'd1;
  localparam logic [2:0] S_COMP   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_SKIP   = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  // The timer only has to reach TIMEOUT_CYCLES-1 before the turn is left.
  localparam int            TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam int            SW           = $clog2(MAX_STRIKES + 1);
  localparam logic [SW-1:0] STRIKE_LIMIT = SW'(MAX_STRIKES);
  localparam logic [PW-1:0] LAST_SEAT    = PW'(NUM_PLAYERS - 1);

  logic [2:0]        state, state_d;
  logic [PW-1:0]     turn_d, turn_adv;
  logic [PW-1:0]     winner_d;
  logic              winner_valid_d, draw_d;
  logic [MOVE_W-1:0] move_count_d, move_count_inc;
  logic [TW-1:0]     timer, timer_d;
  logic [SW-1:0]     strikes, strikes_d;
  logic [2:0]        seat_state;
  logic              timeout_hit, legal_move, illegal_move;

  assign move_count_inc = (move_count == '1) ? move_count : move_count + 1'b1;
  assign turn_adv       = (turn == LAST_SEAT) ? '0 : turn + 1'b1;
  assign seat_state     = COMP_MASK[turn_adv] ? S_COMP : S_PROMPT;
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);
  assign legal_move     = move_valid && !wrong_move;
  assign illegal_move   = move_valid && wrong_move;

  always_comb begin
    state_d        = state;
    turn_d         = turn;
    winner_d       = winner;
    winner_valid_d = winner_valid;
    draw_d         = draw;
    move_count_d   = move_count;
    // Timer and strikes are zero outside PROMPT, so every PROMPT entry
    // starts them from zero.
    timer_d        = '0;
    strikes_d      = '0;

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          turn_d         = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          draw_d         = 1'b0;
          move_count_d   = '0;
          state_d        = COMP_MASK[0] ? S_COMP : S_PROMPT;
        end
      end

      S_PROMPT: begin
        timer_d   = (TIMEOUT_CYCLES != 0) ? timer + 1'b1 : '0;
        strikes_d = strikes;
        // A legal move wins over an expiring timer in the same cycle.
        if (legal_move) begin
          move_count_d = move_count_inc;
          state_d      = S_CHECK;
        end else if ((illegal_move && (strikes + 1'b1 == STRIKE_LIMIT)) || timeout_hit) begin
          state_d = S_SKIP;
        end else if (illegal_move) begin
          strikes_d = strikes + 1'b1;
        end
      end

      S_COMP: begin
        if (comp_done) begin
          move_count_d = move_count_inc;
          state_d      = S_CHECK;
        end
      end

      S_CHECK: begin
        if (win) begin
          winner_d       = turn;
          winner_valid_d = 1'b1;
          state_d        = S_OVER;
        end else if (filled) begin
          draw_d  = 1'b1;
          state_d = S_OVER;
        end else begin
          turn_d  = turn_adv;
          state_d = seat_state;
        end
      end

      S_SKIP: begin
        turn_d  = turn_adv;
        state_d = seat_state;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      turn         <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      draw         <= 1'b0;
      move_count   <= '0;
      timer        <= '0;
      strikes      <= '0;
      comp_go      <= 1'b0;
    end else begin
      state        <= state_d;
      turn         <= turn_d;
      winner       <= winner_d;
      winner_valid <= winner_valid_d;
      draw         <= draw_d;
      move_count   <= move_count_d;
      timer        <= timer_d;
      strikes      <= strikes_d;
      // Registered so it is high exactly in the first cycle of COMP.
      comp_go      <= (state_d == S_COMP) && (state != S_COMP);
    end
  end

  assign player_prompt = (state == S_PROMPT);
  assign game_over     = (state == S_OVER);
  assign skip          = (state == S_SKIP);
  assign state_dbg     = state;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer with 3 seats (seat 1 computer-driven), a 5-cycle
// human timeout, 3 strikes and a 2-bit move counter.
// Observable turn events (prompt rise, comp_go, skip, game-over rise) are
// predicted by the driver into exp_q and checked by an independent monitor.
module tb_turn_sequencer;

  localparam logic [1:0] EV_P = 2'd0;
  localparam logic [1:0] EV_C = 2'd1;
  localparam logic [1:0] EV_S = 2'd2;
  localparam logic [1:0] EV_O = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PROMPT = 3'd1;
  localparam logic [2:0] ST_COMP   = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_SKIP   = 3'd4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       start, move_valid, wrong_move, comp_done, win, filled;
  logic [1:0] turn, winner, move_count;
  logic       player_prompt, comp_go, game_over, winner_valid, draw, skip;
  logic [2:0] state_dbg;

  turn_sequencer #(
    .NUM_PLAYERS(3), .COMP_MASK(3'b010), .TIMEOUT_CYCLES(5),
    .MAX_STRIKES(3), .MOVE_W(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .move_valid(move_valid),
    .wrong_move(wrong_move), .comp_done(comp_done), .win(win), .filled(filled),
    .turn(turn), .player_prompt(player_prompt), .comp_go(comp_go),
    .game_over(game_over), .winner(winner), .winner_valid(winner_valid),
    .draw(draw), .skip(skip), .move_count(move_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [9:0] ev(input logic [1:0] k, input logic [1:0] t, input logic [1:0] m,
                                    input logic [1:0] w, input logic wv, input logic d);
    return {k, t, m, w, wv, d};
  endfunction

  // ---------------- monitor ----------------
  logic       prev_prompt = 1'b0;
  logic       prev_over   = 1'b0;
  logic       mon_hit;
  logic [1:0] mon_kind;
  logic [9:0] mon_act, mon_exp;

  always @(negedge clock) begin
    mon_hit  = 1'b1;
    mon_kind = EV_P;
    if (player_prompt && !prev_prompt) mon_kind = EV_P;
    else if (comp_go)                  mon_kind = EV_C;
    else if (skip)                     mon_kind = EV_S;
    else if (game_over && !prev_over)  mon_kind = EV_O;
    else                               mon_hit  = 1'b0;
    if (mon_hit) begin
      mon_act = ev(mon_kind, turn, move_count, winner, winner_valid, draw);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", {22'd0, mon_act}, {22'd0, mon_exp});
      end
    end
    prev_prompt = player_prompt;
    prev_over   = game_over;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_prompt();
    for (int i = 0; i < 20; i++) begin
      if (player_prompt) return;
      tick();
    end
    n_checks++;
    $display("FAIL wait_prompt: got no prompt expected prompt within 20 cycles");
  endtask

  task automatic wait_comp_go();
    for (int i = 0; i < 20; i++) begin
      if (comp_go) return;
      tick();
    end
    n_checks++;
    $display("FAIL wait_comp_go: got no comp_go expected comp_go within 20 cycles");
  endtask

  task automatic human_move(input logic bad);
    move_valid = 1'b1;
    wrong_move = bad;
    tick();
    move_valid = 1'b0;
    wrong_move = 1'b0;
  endtask

  task automatic board_cycle(input logic w, input logic f);
    win    = w;
    filled = f;
    tick();
    win    = 1'b0;
    filled = 1'b0;
  endtask

  task automatic comp_finish(input logic w, input logic f);
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
    board_cycle(w, f);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 0; move_valid = 0; wrong_move = 0; comp_done = 0; win = 0; filled = 0;
    tick(); tick();
    check("reset_outputs",
          {turn, player_prompt, comp_go, game_over, winner, winner_valid, draw, skip, move_count, state_dbg}, 0);
    reset = 1'b0;
    tick();

    // Game 1: legal move at cycle 3, computer reply, wrap-around.
    exp_q.push_back(ev(EV_P, 0, 0, 0, 0, 0));
    pulse_start();
    wait_prompt();
    tick(); tick();
    exp_q.push_back(ev(EV_C, 1, 1, 0, 0, 0));
    human_move(1'b0);
    check("check_after_move", {player_prompt, state_dbg}, {1'b0, ST_CHECK});
    board_cycle(0, 0);
    wait_comp_go();
    tick();
    check("comp_go_single", {comp_go, state_dbg}, {1'b0, ST_COMP});
    // move_valid and start are both ignored while the engine works.
    move_valid = 1'b1; start = 1'b1;
    tick();
    move_valid = 1'b0; start = 1'b0;
    exp_q.push_back(ev(EV_P, 2, 2, 0, 0, 0));
    comp_finish(0, 0);

    // Timeout on seat 2, with an ignored start in PROMPT.
    exp_q.push_back(ev(EV_S, 2, 2, 0, 0, 0));
    exp_q.push_back(ev(EV_P, 0, 2, 0, 0, 0));
    wait_prompt();
    tick(); start = 1'b1; tick(); start = 1'b0; tick(); tick();
    check("pre_timeout", {skip, player_prompt}, 2'b01);
    tick();
    check("timeout_skip", {skip, state_dbg}, {1'b1, ST_SKIP});
    tick();

    // Two strikes then a legal move on seat 0.
    exp_q.push_back(ev(EV_C, 1, 3, 0, 0, 0));
    wait_prompt();
    human_move(1'b1);
    human_move(1'b1);
    human_move(1'b0);
    check("strikes_then_legal", state_dbg, ST_CHECK);
    board_cycle(0, 0);
    wait_comp_go();
    exp_q.push_back(ev(EV_P, 2, 3, 0, 0, 0));
    comp_finish(0, 0);

    // Three strikes on seat 2.
    exp_q.push_back(ev(EV_S, 2, 3, 0, 0, 0));
    exp_q.push_back(ev(EV_P, 0, 3, 0, 0, 0));
    wait_prompt();
    human_move(1'b1);
    human_move(1'b1);
    human_move(1'b1);
    check("strike_skip", {skip, state_dbg}, {1'b1, ST_SKIP});
    tick();

    // Legal move in the expiry cycle, then a computer win.
    exp_q.push_back(ev(EV_C, 1, 3, 0, 0, 0));
    wait_prompt();
    tick(); tick(); tick(); tick();
    human_move(1'b0);
    check("expiry_move", {skip, state_dbg}, {1'b0, ST_CHECK});
    board_cycle(0, 0);
    wait_comp_go();
    exp_q.push_back(ev(EV_O, 1, 3, 1, 1, 0));
    comp_finish(1, 0);
    tick(); tick();
    check("over_hold", {game_over, winner, winner_valid, draw, move_count}, {1'b1, 2'd1, 1'b1, 1'b0, 2'd3});

    // Game 2: draw.
    exp_q.push_back(ev(EV_P, 0, 0, 0, 0, 0));
    pulse_start();
    wait_prompt();
    exp_q.push_back(ev(EV_C, 1, 1, 0, 0, 0));
    human_move(1'b0);
    board_cycle(0, 0);
    wait_comp_go();
    exp_q.push_back(ev(EV_O, 1, 2, 0, 0, 1));
    comp_finish(0, 1);
    tick();

    // Game 3: win and filled together, win has priority.
    exp_q.push_back(ev(EV_P, 0, 0, 0, 0, 0));
    pulse_start();
    wait_prompt();
    exp_q.push_back(ev(EV_C, 1, 1, 0, 0, 0));
    human_move(1'b0);
    board_cycle(0, 0);
    wait_comp_go();
    exp_q.push_back(ev(EV_O, 1, 2, 1, 1, 0));
    comp_finish(1, 1);
    tick();

    // Game 4: reset while comp_go is high.
    exp_q.push_back(ev(EV_P, 0, 0, 0, 0, 0));
    pulse_start();
    wait_prompt();
    human_move(1'b0);
    board_cycle(0, 0);
    check("comp_go_before_reset", {comp_go, state_dbg}, {1'b1, ST_COMP});
    #1 reset = 1'b1;
    #1;
    check("async_reset",
          {turn, player_prompt, comp_go, game_over, winner, winner_valid, draw, skip, move_count, state_dbg}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) tick();
    check("idle_after_reset", {player_prompt, comp_go, move_count, state_dbg}, {1'b0, 1'b0, 2'd0, ST_IDLE});
    exp_q.push_back(ev(EV_P, 0, 0, 0, 0, 0));
    pulse_start();
    wait_prompt();
    tick(); tick();
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    $display("FAIL watchdog: got time limit expected end of stimulus");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
